// File: rtl/bpc_comp_stream_if.sv
// ----------------------------------------------------------------------------
// bpc_comp_stream_if
// Bundles the beat input stream and the symbol output stream of the bit-plane
// compressor.
//   slave  : compressor side (consumes beats, produces symbols)
//   master : producer/consumer side (testbench or surrounding logic)
// Signals:
//   data_i/valid_i/ready_o/sop_i/eop_i : input beat stream
//   data_o/size_o/sop_o/eop_o/valid_o/ready_i : output symbol stream
//   err_o : one-cycle framing error pulse
// ----------------------------------------------------------------------------
interface bpc_comp_stream_if #(
  parameter int WORD_W      = 16,
  parameter int BEAT_WORDS  = 4,
  parameter int BLOCK_BEATS = 16
);
  localparam int N    = BEAT_WORDS * BLOCK_BEATS;
  localparam int SZ_W = $clog2(N + 1);

  logic [WORD_W*BEAT_WORDS-1:0] data_i;
  logic                         valid_i;
  logic                         ready_o;
  logic                         sop_i;
  logic                         eop_i;
  logic [N-1:0]                 data_o;
  logic [SZ_W-1:0]              size_o;
  logic                         sop_o;
  logic                         eop_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         err_o;

  modport slave (
    input  data_i, valid_i, sop_i, eop_i, ready_i,
    output ready_o, data_o, size_o, sop_o, eop_o, valid_o, err_o
  );

  modport master (
    output data_i, valid_i, sop_i, eop_i, ready_i,
    input  ready_o, data_o, size_o, sop_o, eop_o, valid_o, err_o
  );
endinterface

// File: rtl/bpc_comp_stream.sv
// ----------------------------------------------------------------------------
// bpc_comp_stream
// Streaming bit-plane compressor. Captures a block of N = BEAT_WORDS*BLOCK_BEATS
// words, forms base-relative deltas, transposes them into delta bit-planes
// (DBP), XORs adjacent planes (DBX) and emits one variable-length symbol per
// cycle on a valid/ready stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   s (slave)  : beat input (data_i, valid_i, ready_o, sop_i, eop_i),
//                symbol output (data_o MSB-aligned, size_o, sop_o, eop_o,
//                valid_o, ready_i), err_o framing error pulse
//   blk_cnt_o, bit_cnt_o : block / emitted-bit counters, present only when
//                the macro BPC_COMP_STATS_EN is defined
// ----------------------------------------------------------------------------
module bpc_comp_stream #(
  parameter int WORD_W      = 16,
  parameter int BEAT_WORDS  = 4,
  parameter int BLOCK_BEATS = 16,
  parameter int RUN_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  bpc_comp_stream_if.slave  s
`ifdef BPC_COMP_STATS_EN
  ,
  output logic [31:0]       blk_cnt_o,
  output logic [31:0]       bit_cnt_o
`endif
);
  localparam int N      = BEAT_WORDS * BLOCK_BEATS;
  localparam int SZ_W   = $clog2(N + 1);
  localparam int BCNT_W = $clog2(BLOCK_BEATS + 1);
  localparam int BIDX_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam int PL_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RUNC_W = RUN_W + 1;

  localparam logic [BCNT_W-1:0] BEATS_MAX = BCNT_W'(BLOCK_BEATS);
  localparam logic [RUNC_W-1:0] RUN_MAX   = RUNC_W'((1 << RUN_W) + 1);
  localparam logic [PL_W-1:0]   PL_LAST   = PL_W'(WORD_W - 1);

  typedef enum logic [1:0] {FILL, XFORM, HDR, ENC} state_t;

  state_t                                        state_q;
  logic [BLOCK_BEATS-1:0][BEAT_WORDS-1:0][WORD_W-1:0] beats_q;
  logic [BCNT_W-1:0]                             beat_q, nbeats_q;
  logic                                          open_q;
  logic [WORD_W-1:0][N-2:0]                      dbp_q, dbx_q;
  logic [PL_W-1:0]                               plane_q;
  logic [RUNC_W-1:0]                             run_q;
  logic                                          ready_q, valid_q, sop_q, eop_q, err_q;
  logic [N-1:0]                                  data_q;
  logic [SZ_W-1:0]                               size_q;

  assign s.ready_o = ready_q;
  assign s.valid_o = valid_q;
  assign s.data_o  = data_q;
  assign s.size_o  = size_q;
  assign s.sop_o   = sop_q;
  assign s.eop_o   = eop_q;
  assign s.err_o   = err_q;

  // --------------------------------------------------------------------------
  // Capture framing
  // --------------------------------------------------------------------------
  logic              acc, cls, ferr;
  logic [BCNT_W-1:0] cnt_nx;
  logic [BIDX_W-1:0] wr_idx;

  always_comb begin
    acc    = 1'b0;
    cls    = 1'b0;
    ferr   = 1'b0;
    cnt_nx = beat_q;
    wr_idx = '0;
    if (state_q == FILL && s.valid_i) begin
      if (s.sop_i) begin
        // sop always restarts; a still-open block is abandoned
        acc    = 1'b1;
        cnt_nx = BCNT_W'(1);
        ferr   = open_q;
      end else if (!open_q) begin
        ferr = 1'b1;
      end else begin
        acc    = 1'b1;
        wr_idx = beat_q[BIDX_W-1:0];
        cnt_nx = beat_q + BCNT_W'(1);
      end
      if (acc) begin
        if (s.eop_i) begin
          cls = 1'b1;
        end else if (cnt_nx == BEATS_MAX) begin
          cls  = 1'b1;
          ferr = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Delta / bit-plane transform. Words beyond the captured beats read as the
  // base word so an early eop pads with delta 0.
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0]         base;
  logic [N-2:0][WORD_W-1:0]  delta;
  logic [WORD_W-1:0][N-2:0]  dbp_c, dbx_c;

  assign base = beats_q[0][BEAT_WORDS-1];

  for (genvar k = 0; k < N-1; k++) begin : g_delta
    localparam int IDX = k + 1;
    localparam int B   = IDX / BEAT_WORDS;
    localparam int J   = IDX % BEAT_WORDS;
    logic [WORD_W-1:0] w;
    assign w        = (BCNT_W'(B) < nbeats_q) ? beats_q[B][BEAT_WORDS-1-J] : base;
    assign delta[k] = w - base;
    for (genvar p = 0; p < WORD_W; p++) begin : g_bit
      assign dbp_c[p][N-2-k] = delta[k][WORD_W-1-p];
    end
  end

  assign dbx_c[0] = dbp_c[0];
  for (genvar p = 1; p < WORD_W; p++) begin : g_dbx
    assign dbx_c[p] = dbp_c[p-1] ^ dbp_c[p];
  end

  // --------------------------------------------------------------------------
  // Encoder step: one plane decision per advance
  // --------------------------------------------------------------------------
  logic [N-2:0]       cur_dbx, cur_dbp;
  logic               plane_last;
  logic [RUNC_W-1:0]  run_inc, code_run, run_m2, run_d;
  logic [PL_W-1:0]    plane_d;
  logic               emit, sym_last, is_run;
  logic [N-1:0]       sym_d;
  logic [SZ_W-1:0]    sym_sz;

  assign cur_dbx    = dbx_q[plane_q];
  assign cur_dbp    = dbp_q[plane_q];
  assign plane_last = (plane_q == PL_LAST);

  always_comb begin
    run_inc  = run_q + RUNC_W'(1);
    run_d    = run_q;
    plane_d  = plane_q;
    emit     = 1'b0;
    sym_last = 1'b0;
    is_run   = 1'b0;
    code_run = run_q;
    run_m2   = '0;
    sym_d    = '0;
    sym_sz   = '0;
    if (cur_dbx == '0) begin
      plane_d = plane_q + PL_W'(1);
      // a saturated run, or any run still open at the last plane, goes out now
      if (run_inc == RUN_MAX || plane_last) begin
        emit     = 1'b1;
        is_run   = 1'b1;
        code_run = run_inc;
        sym_last = plane_last;
        run_d    = '0;
      end else begin
        run_d = run_inc;
      end
    end else if (run_q != '0) begin
      // flush the pending run; plane index holds so the plane codes next cycle
      emit     = 1'b1;
      is_run   = 1'b1;
      code_run = run_q;
      run_d    = '0;
    end else begin
      emit     = 1'b1;
      sym_last = plane_last;
      plane_d  = plane_q + PL_W'(1);
      if (&cur_dbx) begin
        sym_sz = SZ_W'(5);
      end else if (cur_dbp == '0) begin
        sym_d[N-5] = 1'b1;
        sym_sz     = SZ_W'(5);
      end else begin
        sym_d  = {1'b1, cur_dbx};
        sym_sz = SZ_W'(N);
      end
    end
    if (is_run) begin
      if (code_run == RUNC_W'(1)) begin
        sym_d[N-1 -: 3] = 3'b001;
        sym_sz          = SZ_W'(3);
      end else begin
        run_m2               = code_run - RUNC_W'(2);
        sym_d[N-1 -: 2]      = 2'b01;
        sym_d[N-3 -: RUN_W]  = run_m2[RUN_W-1:0];
        sym_sz               = SZ_W'(RUN_W + 2);
      end
    end
  end

  // Advance only when the output register is free or being consumed.
  logic step_en;
  assign step_en = ((state_q == HDR) && s.ready_i) ||
                   ((state_q == ENC) && !(valid_q && eop_q) && (!valid_q || s.ready_i));

  // --------------------------------------------------------------------------
  // FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      beats_q  <= '0;
      beat_q   <= '0;
      nbeats_q <= '0;
      open_q   <= 1'b0;
      dbp_q    <= '0;
      dbx_q    <= '0;
      plane_q  <= '0;
      run_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      size_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        FILL: begin
          err_q <= ferr;
          if (acc) begin
            beats_q[wr_idx] <= s.data_i;
            beat_q          <= cnt_nx;
            open_q          <= !cls;
            if (cls) begin
              nbeats_q <= cnt_nx;
              ready_q  <= 1'b0;
              state_q  <= XFORM;
            end
          end
        end
        XFORM: begin
          dbp_q   <= dbp_c;
          dbx_q   <= dbx_c;
          plane_q <= '0;
          run_q   <= '0;
          data_q  <= {base, {(N-WORD_W){1'b0}}};
          size_q  <= SZ_W'(WORD_W);
          sop_q   <= 1'b1;
          eop_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= HDR;
        end
        HDR: ;
        ENC: begin
          if (valid_q && eop_q && s.ready_i) begin
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            size_q  <= '0;
            ready_q <= 1'b1;
            beat_q  <= '0;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
      if (step_en) begin
        valid_q <= emit;
        data_q  <= sym_d;
        size_q  <= sym_sz;
        sop_q   <= 1'b0;
        eop_q   <= sym_last;
        plane_q <= plane_d;
        run_q   <= run_d;
        state_q <= ENC;
      end
    end
  end

`ifdef BPC_COMP_STATS_EN
  logic [31:0] blk_cnt_q, bit_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (valid_q && s.ready_i) begin
      bit_cnt_q <= bit_cnt_q + 32'(size_q);
      if (eop_q) blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt_o = blk_cnt_q;
  assign bit_cnt_o = bit_cnt_q;
`endif

endmodule

// File: tb/tb_bpc_comp_stream.sv
module tb_bpc_comp_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpc_comp_stream_if bus ();

`ifdef BPC_COMP_STATS_EN
  logic [31:0] blk_cnt, bit_cnt;
`endif

  bpc_comp_stream dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
`ifdef BPC_COMP_STATS_EN
    ,
    .blk_cnt_o (blk_cnt),
    .bit_cnt_o (bit_cnt)
`endif
  );

  int vec = 0;
  int miss = 0;
  int err_cnt = 0;

  logic [15:0] blk_w [0:63];
  logic [63:0] got_d   [0:31];
  logic [6:0]  got_s   [0:31];
  logic        got_sop [0:31];
  logic        got_eop [0:31];
  int          n_got;
  bit          fin;
  int          unstable;

  always @(posedge clk) if (bus.err_o === 1'b1) err_cnt++;

  task automatic fill_words(input logic [15:0] base, input logic [15:0] rest);
    blk_w[0] = base;
    for (int i = 1; i < 64; i++) blk_w[i] = rest;
  endtask

  task automatic send_block(input int nbeats, input bit with_eop);
    for (int b = 0; b < nbeats; b++) begin
      bus.data_i  = {blk_w[4*b], blk_w[4*b+1], blk_w[4*b+2], blk_w[4*b+3]};
      bus.valid_i = 1'b1;
      bus.sop_i   = (b == 0);
      bus.eop_i   = with_eop && (b == nbeats - 1);
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    bus.sop_i   = 1'b0;
    bus.eop_i   = 1'b0;
  endtask

  // Gathers symbols until the eop handshake; optionally holds ready_i low on
  // the header and on the last symbol and counts any output movement meanwhile.
  task automatic collect(input int stall_hdr, input int stall_last);
    int st;
    logic [63:0] sd; logic [6:0] ss; logic sp, ep;
    n_got = 0; fin = 1'b0; unstable = 0;
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (bus.valid_o) begin
        st = bus.sop_o ? stall_hdr : (bus.eop_o ? stall_last : 0);
        if (st > 0) begin
          sd = bus.data_o; ss = bus.size_o; sp = bus.sop_o; ep = bus.eop_o;
          bus.ready_i = 1'b0;
          repeat (st) begin
            @(posedge clk); #1;
            if (!bus.valid_o || bus.data_o !== sd || bus.size_o !== ss || bus.sop_o !== sp || bus.eop_o !== ep || bus.ready_o !== 1'b0) unstable++;
          end
          bus.ready_i = 1'b1;
        end
        if (n_got < 32) begin
          got_d[n_got] = bus.data_o; got_s[n_got] = bus.size_o;
          got_sop[n_got] = bus.sop_o; got_eop[n_got] = bus.eop_o;
        end
        n_got++;
        if (bus.eop_o) fin = 1'b1;
      end
      @(posedge clk); #1;
      if (fin) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_i = '0; bus.valid_i = 1'b0; bus.sop_i = 1'b0; bus.eop_i = 1'b0; bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.err_o !== 1'b0 || bus.data_o !== 64'd0 || bus.size_o !== 7'd0 || bus.sop_o !== 1'b0 || bus.eop_o !== 1'b0) begin
      miss++;
      $display("FAIL reset_outputs: got v%b r%b e%b d%h s%0d sop%b eop%b exp v0 r1 e0 d0 s0 sop0 eop0", bus.valid_o, bus.ready_o, bus.err_o, bus.data_o, bus.size_o, bus.sop_o, bus.eop_o);
    end
`ifdef BPC_COMP_STATS_EN
    vec++;
    if (blk_cnt !== 32'd0 || bit_cnt !== 32'd0) begin
      miss++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", blk_cnt, bit_cnt);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_const();
    logic [63:0] ed [0:1] = '{64'h1234_0000_0000_0000, 64'h7800_0000_0000_0000};
    int es [0:1] = '{16, 6};
    int e0 = err_cnt;
    fill_words(16'h1234, 16'h1234);
    send_block(16, 1'b1);
    vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      miss++; $display("FAIL const_xform: got v%b r%b exp v0 r0", bus.valid_o, bus.ready_o);
    end
    @(posedge clk); #1;
    vec++;
    if (bus.valid_o !== 1'b1 || bus.sop_o !== 1'b1 || bus.data_o !== ed[0]) begin
      miss++; $display("FAIL const_latency: got v%b sop%b d%h exp v1 sop1 d%h", bus.valid_o, bus.sop_o, bus.data_o, ed[0]);
    end
    collect(0, 0);
    vec++;
    if (n_got !== 2 || !fin) begin
      miss++; $display("FAIL const_count: got %0d fin%b exp 2 fin1", n_got, fin);
    end
    for (int i = 0; i < 2 && i < n_got; i++) begin
      vec++;
      if (got_d[i] !== ed[i] || got_s[i] !== 7'(es[i]) || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 1)) begin
        miss++; $display("FAIL const_sym%0d: got %h/%0d/%b%b exp %h/%0d/%b%b", i, got_d[i], got_s[i], got_sop[i], got_eop[i], ed[i], es[i], i == 0, i == 1);
      end
    end
    vec++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || err_cnt != e0) begin
      miss++; $display("FAIL const_done: got r%b v%b err%0d exp r1 v0 err0", bus.ready_o, bus.valid_o, err_cnt - e0);
    end
  endtask

  task automatic test_single_bit();
    logic [63:0] ed [0:2] = '{64'h0, 64'h7400_0000_0000_0000, 64'hC000_0000_0000_0000};
    int es [0:2] = '{16, 6, 64};
    fill_words(16'h0000, 16'h0000);
    blk_w[1] = 16'h0001;
    send_block(16, 1'b1);
    collect(0, 0);
    vec++;
    if (n_got !== 3 || !fin) begin
      miss++; $display("FAIL single_count: got %0d fin%b exp 3 fin1", n_got, fin);
    end
    for (int i = 0; i < 3 && i < n_got; i++) begin
      vec++;
      if (got_d[i] !== ed[i] || got_s[i] !== 7'(es[i]) || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 2)) begin
        miss++; $display("FAIL single_sym%0d: got %h/%0d/%b%b exp %h/%0d/%b%b", i, got_d[i], got_s[i], got_sop[i], got_eop[i], ed[i], es[i], i == 0, i == 2);
      end
    end
  endtask

  task automatic test_all_ones();
    logic [63:0] ed [0:3] = '{64'h0, 64'h0, 64'h0, 64'h7000_0000_0000_0000};
    int es [0:3] = '{16, 5, 5, 6};
    fill_words(16'h0000, 16'h8000);
    send_block(16, 1'b1);
    collect(0, 0);
    vec++;
    if (n_got !== 4 || !fin) begin
      miss++; $display("FAIL ones_count: got %0d fin%b exp 4 fin1", n_got, fin);
    end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      vec++;
      if (got_d[i] !== ed[i] || got_s[i] !== 7'(es[i]) || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 3)) begin
        miss++; $display("FAIL ones_sym%0d: got %h/%0d/%b%b exp %h/%0d/%b%b", i, got_d[i], got_s[i], got_sop[i], got_eop[i], ed[i], es[i], i == 0, i == 3);
      end
    end
  endtask

  task automatic test_stall();
    fill_words(16'h1234, 16'h1234);
    send_block(16, 1'b1);
    collect(5, 5);
    vec++;
    if (unstable !== 0) begin
      miss++; $display("FAIL stall_stable: got %0d unstable cycles exp 0", unstable);
    end
    vec++;
    if (n_got !== 2 || !fin) begin
      miss++; $display("FAIL stall_count: got %0d fin%b exp 2 fin1", n_got, fin);
    end
    vec++;
    if (got_d[0] !== 64'h1234_0000_0000_0000 || got_s[0] !== 7'd16 || got_d[1] !== 64'h7800_0000_0000_0000 || got_s[1] !== 7'd6 || got_eop[1] !== 1'b1) begin
      miss++; $display("FAIL stall_syms: got %h/%0d %h/%0d/%b exp 1234..0/16 78..0/6/1", got_d[0], got_s[0], got_d[1], got_s[1], got_eop[1]);
    end
    vec++;
    if (bus.ready_o !== 1'b1) begin
      miss++; $display("FAIL stall_ready: got %b exp 1", bus.ready_o);
    end
  endtask

  task automatic test_early_eop();
    int e0;
    fill_words(16'h1234, 16'h1234);
    e0 = err_cnt;
    send_block(8, 1'b1);
    collect(0, 0);
    vec++;
    if (n_got !== 2 || got_d[0] !== 64'h1234_0000_0000_0000 || got_d[1] !== 64'h7800_0000_0000_0000 || got_s[1] !== 7'd6 || err_cnt != e0) begin
      miss++; $display("FAIL early_eop: got n%0d %h %h/%0d err%0d exp n2 1234..0 78..0/6 err0", n_got, got_d[0], got_d[1], got_s[1], err_cnt - e0);
    end
    e0 = err_cnt;
    send_block(16, 1'b0);
    collect(0, 0);
    vec++;
    if (n_got !== 2 || got_d[0] !== 64'h1234_0000_0000_0000 || got_d[1] !== 64'h7800_0000_0000_0000 || got_eop[1] !== 1'b1 || err_cnt != e0 + 1) begin
      miss++; $display("FAIL no_eop: got n%0d %h %h eop%b err%0d exp n2 1234..0 78..0 eop1 err1", n_got, got_d[0], got_d[1], got_eop[1], err_cnt - e0);
    end
  endtask

  task automatic test_framing();
    int e0 = err_cnt;
    bus.data_i = 64'hFFFF_FFFF_FFFF_FFFF; bus.valid_i = 1'b1; bus.sop_i = 1'b0; bus.eop_i = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    vec++;
    if (bus.err_o !== 1'b1 || bus.ready_o !== 1'b1) begin
      miss++; $display("FAIL stray_beat: got err%b r%b exp err1 r1", bus.err_o, bus.ready_o);
    end
    @(posedge clk); #1;
    vec++;
    if (bus.err_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      miss++; $display("FAIL stray_pulse: got err%b v%b exp err0 v0", bus.err_o, bus.valid_o);
    end
    fill_words(16'hFFFF, 16'h0F0F);
    send_block(3, 1'b0);
    fill_words(16'h1234, 16'h1234);
    send_block(16, 1'b1);
    collect(0, 0);
    vec++;
    if (n_got !== 2 || got_d[0] !== 64'h1234_0000_0000_0000 || got_d[1] !== 64'h7800_0000_0000_0000 || err_cnt != e0 + 2) begin
      miss++; $display("FAIL restart_sop: got n%0d %h %h err%0d exp n2 1234..0 78..0 err2", n_got, got_d[0], got_d[1], err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    fill_words(16'h0000, 16'h0000);
    blk_w[1] = 16'h0001;
    bus.ready_i = 1'b1;
    send_block(16, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      miss++; $display("FAIL rst_async: got v%b r%b exp v0 r1", bus.valid_o, bus.ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      miss++; $display("FAIL rst_after: got v%b r%b exp v0 r1", bus.valid_o, bus.ready_o);
    end
    begin
      int seen = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (bus.valid_o) seen++;
      end
      vec++;
      if (seen != 0) begin
        miss++; $display("FAIL rst_residue: got %0d valid cycles exp 0", seen);
      end
    end
    fill_words(16'h1234, 16'h1234);
    send_block(16, 1'b1);
    collect(0, 0);
    vec++;
    if (n_got !== 2 || got_d[0] !== 64'h1234_0000_0000_0000 || got_s[0] !== 7'd16 || got_sop[0] !== 1'b1 || got_d[1] !== 64'h7800_0000_0000_0000 || got_s[1] !== 7'd6 || got_eop[1] !== 1'b1) begin
      miss++; $display("FAIL rst_fresh: got n%0d %h/%0d %h/%0d exp n2 1234..0/16 78..0/6", n_got, got_d[0], got_s[0], got_d[1], got_s[1]);
    end
`ifdef BPC_COMP_STATS_EN
    vec++;
    if (blk_cnt !== 32'd1 || bit_cnt !== 32'd22) begin
      miss++; $display("FAIL rst_stats: got %0d/%0d exp 1/22", blk_cnt, bit_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_const();
    test_single_bit();
    test_all_ones();
    test_stall();
    test_early_eop();
    test_framing();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
